// File: rtl/compare_pkg.sv
// Shared definitions for the sliced magnitude comparator: one-hot result
// encoding {A>B, A<B, A=B} and the controller state type.
package compare_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } state_e;

    // Number of index bits needed to address n slices (at least one bit).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/slice_compare.sv
// Purely combinational unsigned compare of one operand slice; equality is
// implied when neither gt nor lt is set.
module slice_compare #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/data_compare_seq.sv
// Multi-cycle cascadable magnitude comparator: walks the operands one slice
// per cycle from the most-significant end and stops on the first difference.
module data_compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iMode,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_r;
    state_e           state_n_s;
    logic [IDX_W-1:0] k_r;
    logic [IDX_W-1:0] k_n_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       casc_r;
    logic             mode_r;
    logic             done_r;
    logic             done_n_s;
    logic [2:0]       data_r;
    logic [2:0]       data_n_s;
    logic             load_s;

    logic [WIDTH-1:0] a_eff_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [SLICE-1:0] a_sl_s [NSLICE];
    logic [SLICE-1:0] b_sl_s [NSLICE];
    logic [SLICE-1:0] a_cur_s;
    logic [SLICE-1:0] b_cur_s;
    logic             gt_s;
    logic             lt_s;

    // Signed mode: flipping both sign bits turns two's-complement order into unsigned order.
    always_comb begin
        a_eff_s = a_r;
        b_eff_s = b_r;
        a_eff_s[WIDTH-1] = a_r[WIDTH-1] ^ mode_r;
        b_eff_s[WIDTH-1] = b_r[WIDTH-1] ^ mode_r;
    end

    for (genvar s = 0; s < NSLICE; s++) begin : g_slices
        assign a_sl_s[s] = a_eff_s[s*SLICE +: SLICE];
        assign b_sl_s[s] = b_eff_s[s*SLICE +: SLICE];
    end

    // Slice multiplexer driven by the current slice index.
    always_comb begin
        a_cur_s = a_sl_s[k_r];
        b_cur_s = b_sl_s[k_r];
    end

    slice_compare #(
        .SLICE (SLICE)
    ) u_slice_compare (
        .a  (a_cur_s),
        .b  (b_cur_s),
        .gt (gt_s),
        .lt (lt_s)
    );

    // Next-state, index and result logic for the IDLE/COMPARE controller.
    always_comb begin
        state_n_s = state_r;
        k_n_s     = k_r;
        done_n_s  = 1'b0;
        data_n_s  = data_r;
        load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iStart) begin
                    load_s    = 1'b1;
                    k_n_s     = IDX_TOP;
                    state_n_s = ST_COMPARE;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (gt_s) begin
                    data_n_s  = CMP_GT;
                    done_n_s  = 1'b1;
                    state_n_s = ST_IDLE;
                end else if (lt_s) begin
                    data_n_s  = CMP_LT;
                    done_n_s  = 1'b1;
                    state_n_s = ST_IDLE;
                end else if (k_r == IDX_ZERO) begin
                    // All slices equal: the less-significant stage decides, passed verbatim.
                    data_n_s  = casc_r;
                    done_n_s  = 1'b1;
                    state_n_s = ST_IDLE;
                end else begin
                    k_n_s     = k_r - IDX_ONE;
                    state_n_s = ST_COMPARE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                k_n_s     = IDX_ZERO;
                data_n_s  = CMP_NONE;
            end
        endcase
    end

    // Controller state, slice index and registered outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= ST_IDLE;
            k_r     <= IDX_ZERO;
            done_r  <= 1'b0;
            data_r  <= CMP_NONE;
        end else begin
            state_r <= state_n_s;
            k_r     <= k_n_s;
            done_r  <= done_n_s;
            data_r  <= data_n_s;
        end
    end

    // Operand, cascade and mode capture on an accepted start.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            casc_r <= CMP_NONE;
            mode_r <= 1'b0;
        end else if (load_s) begin
            a_r    <= iData_a;
            b_r    <= iData_b;
            casc_r <= iData;
            mode_r <= iMode;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            casc_r <= casc_r;
            mode_r <= mode_r;
        end
    end

    assign oBusy = (state_r == ST_COMPARE);
    assign oDone = done_r;
    assign oData = data_r;

endmodule
